// File: rtl/fifo_pkg.sv
// Shared sizing helpers and default thresholds for the synchronous FIFO.
// Pointer and count widths are derived here so the top and the bench agree.
package fifo_pkg;

    localparam int unsigned DEF_DATA_WIDTH   = 32'd8;
    localparam int unsigned DEF_FIFO_DEPTH   = 32'd8;
    localparam int unsigned DEF_AEMPTY_TH    = 32'd2;
    localparam int unsigned DEF_AFULL_MARGIN = 32'd2;

    // Per-cycle accepted-operation code: {write accepted, read accepted}.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } op_e;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 32'd1;
    endfunction

    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 32'd1;
    endfunction

    function automatic int unsigned def_afull_th(input int unsigned depth);
        return depth - DEF_AFULL_MARGIN;
    endfunction

endpackage

// File: rtl/fifo_dp_ram.sv
// Storage array for the FIFO: one write port and one registered, enabled read port.
// All entries and the read register clear asynchronously on reset.
module fifo_dp_ram #(
    parameter int unsigned DATA_WIDTH = 32'd8,
    parameter int unsigned DEPTH      = 32'd8,
    parameter int unsigned ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_r;

    // Write port: store the word at the write address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read port: capture the addressed word only when enabled, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= '0;
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/fifo_sync_buffer.sv
// Single-clock FIFO: pointer, occupancy, threshold and sticky error logic
// around a fifo_dp_ram storage block.
module fifo_sync_buffer
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned AFULL_TH   = def_afull_th(FIFO_DEPTH),
    parameter int unsigned AEMPTY_TH  = DEF_AEMPTY_TH
) (
    input  logic                                W_CLK,
    input  logic                                W_RST,
    input  logic [DATA_WIDTH-1:0]               WR_DATA,
    input  logic                                Wr_en,
    input  logic                                Rd_en,
    input  logic                                CLR_ERR,
    output logic [DATA_WIDTH-1:0]               RD_DATA,
    output logic                                RD_VALID,
    output logic                                FULL,
    output logic                                EMPTY,
    output logic                                AFULL,
    output logic                                AEMPTY,
    output logic [count_width(FIFO_DEPTH)-1:0]  COUNT,
    output logic                                OVERFLOW,
    output logic                                UNDERFLOW
);

    localparam int unsigned PTR_W = ptr_width(FIFO_DEPTH);
    localparam int unsigned AW    = PTR_W - 32'd1;
    localparam int unsigned CW    = count_width(FIFO_DEPTH);

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nxt_s;
    logic             rd_valid_r;
    logic             overflow_r;
    logic             underflow_r;
    logic             full_s;
    logic             empty_s;
    logic             wr_acc_s;
    logic             rd_acc_s;
    op_e              op_s;

    // Same pointers mean empty; same slot on opposite laps means full.
    assign empty_s  = (wr_ptr_r == rd_ptr_r);
    assign full_s   = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) &&
                      (wr_ptr_r[AW] != rd_ptr_r[AW]);
    assign wr_acc_s = Wr_en & ~full_s;
    assign rd_acc_s = Rd_en & ~empty_s;
    assign op_s     = op_e'({wr_acc_s, rd_acc_s});

    // Next occupancy from the accepted operations of this cycle.
    always_comb begin
        count_nxt_s = count_r;
        case (op_s)
            OP_WRITE: count_nxt_s = count_r + CW'(1);
            OP_READ:  count_nxt_s = count_r - CW'(1);
            OP_BOTH:  count_nxt_s = count_r;
            OP_IDLE:  count_nxt_s = count_r;
            default:  count_nxt_s = count_r;
        endcase
    end

    // Pointers, occupancy and read-valid pulse.
    always_ff @(posedge W_CLK or negedge W_RST) begin
        if (!W_RST) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            rd_valid_r <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r    <= count_nxt_s;
            rd_valid_r <= rd_acc_s;
        end
    end

    // Sticky error flags; a new error in the same cycle wins over the clear.
    always_ff @(posedge W_CLK or negedge W_RST) begin
        if (!W_RST) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (Wr_en && full_s) begin
                overflow_r <= 1'b1;
            end else if (CLR_ERR) begin
                overflow_r <= 1'b0;
            end
            if (Rd_en && empty_s) begin
                underflow_r <= 1'b1;
            end else if (CLR_ERR) begin
                underflow_r <= 1'b0;
            end
        end
    end

    fifo_dp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .ADDR_W     (AW)
    ) u_ram (
        .clk     (W_CLK),
        .rst_n   (W_RST),
        .wr_en   (wr_acc_s),
        .wr_addr (wr_ptr_r[AW-1:0]),
        .wr_data (WR_DATA),
        .rd_en   (rd_acc_s),
        .rd_addr (rd_ptr_r[AW-1:0]),
        .rd_data (RD_DATA)
    );

    assign RD_VALID  = rd_valid_r;
    assign FULL      = full_s;
    assign EMPTY     = empty_s;
    assign COUNT     = count_r;
    assign AFULL     = (32'(count_r) >= AFULL_TH);
    assign AEMPTY    = (32'(count_r) <= AEMPTY_TH);
    assign OVERFLOW  = overflow_r;
    assign UNDERFLOW = underflow_r;

endmodule

// File: doc/fifo_sync_buffer.md
FIFO_SYNC_BUFFER -- requirements
Module: fifo_sync_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, number of entries; power of two, at least 4.
REQ-003 SHALL have parameter AFULL_TH, default FIFO_DEPTH-2, count at or above which AFULL asserts.
REQ-004 SHALL have parameter AEMPTY_TH, default 2, count at or below which AEMPTY asserts.
REQ-005 SHALL have W_CLK  input  1  sole clock; all state on its rising edge.
REQ-006 SHALL have W_RST  input  1  asynchronous, active-low reset.
REQ-007 SHALL have WR_DATA  input  DATA_WIDTH  write word.
REQ-008 SHALL have Wr_en  input  1  write request.
REQ-009 SHALL have Rd_en  input  1  read request.
REQ-010 SHALL have CLR_ERR  input  1  clears the sticky error flags.
REQ-011 SHALL have RD_DATA  output  DATA_WIDTH  registered read word.
REQ-012 SHALL have RD_VALID  output  1  RD_DATA holds a newly popped word this cycle.
REQ-013 SHALL have FULL, EMPTY, AFULL, AEMPTY  output  1 each  occupancy flags.
REQ-014 SHALL have COUNT  output  clog2(FIFO_DEPTH)+1  current occupancy.
REQ-015 SHALL have OVERFLOW, UNDERFLOW  output  1 each  sticky error flags.

Function
REQ-016 SHALL accept a write when Wr_en=1 and FULL=0, with FULL sampled before the edge.
REQ-017 SHALL accept a read when Rd_en=1 and EMPTY=0, with EMPTY sampled before the edge.
REQ-018 SHALL store an accepted write at the write pointer and then increment that pointer.
REQ-019 SHALL load RD_DATA with the entry at the read pointer on an accepted read, then increment that pointer; RD_DATA holds its value otherwise.
REQ-020 SHALL assert RD_VALID for exactly the cycle after each accepted read (latency 1).
REQ-021 SHALL use pointers of width clog2(FIFO_DEPTH)+1; the MSB is the wrap bit and the lower bits wrap from FIFO_DEPTH-1 to 0.
REQ-022 SHALL derive EMPTY from pointers equal, and FULL from lower bits equal with wrap bits differing.
REQ-023 SHALL register COUNT: +1 on write-only, -1 on read-only, unchanged on both or neither; range 0..FIFO_DEPTH.
REQ-024 SHALL derive AFULL as COUNT>=AFULL_TH and AEMPTY as COUNT<=AEMPTY_TH.
REQ-025 SHALL perform both operations on a same-cycle read and write when 0<COUNT<FIFO_DEPTH, leaving COUNT unchanged.
REQ-026 SHALL perform only the write on a same-cycle read and write when EMPTY; there is no write-through, and RD_VALID stays 0.
REQ-027 SHALL perform only the read on a same-cycle read and write when FULL; the write is dropped.
REQ-028 SHALL set OVERFLOW on Wr_en while FULL, and set UNDERFLOW on Rd_en while EMPTY.
REQ-029 SHALL drop a rejected request without changing pointers, memory or COUNT.
REQ-030 SHALL clear OVERFLOW and UNDERFLOW on CLR_ERR=1; a same-cycle set takes priority over the clear.

Reset
REQ-031 SHALL, on W_RST=0 and without waiting for a clock edge, clear both pointers, COUNT, RD_DATA, RD_VALID, OVERFLOW, UNDERFLOW and all memory entries to 0.
REQ-032 SHALL drive, during reset, EMPTY=1, FULL=0, AEMPTY=1, and AFULL=(AFULL_TH==0).
REQ-033 SHALL discard any in-flight operation on reset asserted mid-operation, and accept a request on the first rising edge after deassertion.

Structure
REQ-034 SHALL place pointer-width and count-width calculations and the default thresholds in shared package fifo_pkg.
REQ-035 SHALL implement storage as one sub-module fifo_dp_ram: one write port, one registered read port with read enable, and asynchronous reset.
REQ-036 SHALL keep pointer, flag, COUNT and error logic in fifo_sync_buffer.

Verification
REQ-037 SHALL cover: reset, write 8 words 0x01..0x08 -> FULL=1, COUNT=8, AFULL=1 from COUNT=6.
REQ-038 SHALL cover: 8 reads -> RD_DATA 0x01..0x08 in order, each 1 cycle after Rd_en, RD_VALID pulses, EMPTY=1 at end.
REQ-039 SHALL cover: Wr_en with 0xAA while FULL -> OVERFLOW=1, contents unchanged; CLR_ERR pulse -> OVERFLOW=0.
REQ-040 SHALL cover: Rd_en while EMPTY -> UNDERFLOW=1, RD_VALID=0; simultaneous Rd_en+Wr_en while EMPTY -> COUNT=1, no RD_VALID.
REQ-041 SHALL cover: 20 cycles of simultaneous read/write at COUNT=4 -> COUNT stays 4, data in order across pointer wrap.
REQ-042 SHALL cover: W_RST asserted mid-burst between clock edges -> all outputs at reset values immediately, EMPTY=1.
